// File: rtl/rv32i_core.sv
// ============================================================================
// Module   : rv32i_core (+ rv32i_regs, rv32i_inst_mem, rv32i_data_mem)
// Brief    : Single-cycle RV32I core with internal register file and memories.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv32i_regs #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [CPU_WIDTH-1:0] rs1_data,
    output logic [CPU_WIDTH-1:0] rs2_data,
    input  logic                 we,
    input  logic [4:0]           rd_addr,
    input  logic [CPU_WIDTH-1:0] rd_data
);
    logic [CPU_WIDTH-1:0] regs [0:31];

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && rd_addr != 5'd0) begin
            regs[rd_addr] <= rd_data;
        end
    end
endmodule

module rv32i_inst_mem #(
    parameter int INST_MEM_ADDR_DEPTH = 4096,
    parameter int AW = $clog2(INST_MEM_ADDR_DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [31:0]   data,
    // Load port; the core ties it off and programs arrive by backdoor preload
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data
);
    logic [31:0] inst_mem [0:INST_MEM_ADDR_DEPTH-1];

    assign data = inst_mem[addr];

    always_ff @(posedge clk) begin
        if (load_we) inst_mem[load_addr] <= load_data;
    end
endmodule

module rv32i_data_mem #(
    parameter int DATA_MEM_ADDR_DEPTH = 4096,
    parameter int AW = $clog2(DATA_MEM_ADDR_DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] data_mem [0:DATA_MEM_ADDR_DEPTH-1];

    assign rdata = data_mem[addr];

    always_ff @(posedge clk) begin
        if (be[0]) data_mem[addr][7:0]   <= wdata[7:0];
        if (be[1]) data_mem[addr][15:8]  <= wdata[15:8];
        if (be[2]) data_mem[addr][23:16] <= wdata[23:16];
        if (be[3]) data_mem[addr][31:24] <= wdata[31:24];
    end
endmodule

module rv32i_core #(
    parameter int                 CPU_WIDTH           = 32,
    parameter int                 INST_MEM_ADDR_DEPTH = 4096,
    parameter int                 DATA_MEM_ADDR_DEPTH = 4096,
    parameter logic [CPU_WIDTH-1:0] RESET_PC          = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst_n
);
    localparam int IAW = $clog2(INST_MEM_ADDR_DEPTH);
    localparam int DAW = $clog2(DATA_MEM_ADDR_DEPTH);
    localparam int W   = CPU_WIDTH;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [W-1:0] pc, next_pc, pc_plus4;
    logic [31:0]  inst;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [4:0]   rd, rs1, rs2;
    logic [W-1:0] rs1_data, rs2_data;
    logic [W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [W-1:0] alu_b, alu_y, mem_addr, mem_rdata, store_data;
    logic [7:0]   load_byte;
    logic [15:0]  load_half;
    logic [3:0]   mem_be;
    logic         rd_we, br_taken;
    logic [W-1:0] rd_data;
    logic         unused_bits;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign imm_i = {{(W-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(W-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{(W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign pc_plus4 = pc + W'(4);
    assign mem_addr = rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign unused_bits = ^{1'b0, pc[W-1:IAW+2], pc[1:0], mem_addr[W-1:DAW+2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else        pc <= next_pc;
    end

    rv32i_regs #(.CPU_WIDTH(W)) u_regs_0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (rd_we),
        .rd_addr  (rd),
        .rd_data  (rd_data)
    );

    rv32i_inst_mem #(.INST_MEM_ADDR_DEPTH(INST_MEM_ADDR_DEPTH)) u_inst_mem_0 (
        .clk       (clk),
        .addr      (pc[IAW+1:2]),
        .data      (inst),
        .load_we   (1'b0),
        .load_addr ('0),
        .load_data ('0)
    );

    rv32i_data_mem #(.DATA_MEM_ADDR_DEPTH(DATA_MEM_ADDR_DEPTH)) u_data_mem_0 (
        .clk   (clk),
        .addr  (mem_addr[DAW+1:2]),
        .be    (mem_be),
        .wdata (store_data),
        .rdata (mem_rdata)
    );

    // Shared ALU; bit 30 selects SUB only for register-register ops, SRA for both.
    always_comb begin
        alu_b = (opcode == OPC_OP) ? rs2_data : imm_i;
        unique case (funct3)
            3'b000:  alu_y = (opcode == OPC_OP && inst[30]) ? rs1_data - alu_b : rs1_data + alu_b;
            3'b001:  alu_y = rs1_data << alu_b[4:0];
            3'b010:  alu_y = {{(W-1){1'b0}}, $signed(rs1_data) < $signed(alu_b)};
            3'b011:  alu_y = {{(W-1){1'b0}}, rs1_data < alu_b};
            3'b100:  alu_y = rs1_data ^ alu_b;
            3'b101:  alu_y = inst[30] ? W'($signed(rs1_data) >>> alu_b[4:0]) : rs1_data >> alu_b[4:0];
            3'b110:  alu_y = rs1_data | alu_b;
            default: alu_y = rs1_data & alu_b;
        endcase
    end

    always_comb begin
        unique case (funct3)
            3'b000:  br_taken = (rs1_data == rs2_data);
            3'b001:  br_taken = (rs1_data != rs2_data);
            3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_taken = (rs1_data <  rs2_data);
            3'b111:  br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        unique case (mem_addr[1:0])
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        next_pc    = pc_plus4;
        rd_we      = 1'b0;
        rd_data    = '0;
        mem_be     = 4'b0000;
        store_data = '0;
        unique case (opcode)
            OPC_LUI:   begin rd_we = 1'b1; rd_data = imm_u; end
            OPC_AUIPC: begin rd_we = 1'b1; rd_data = pc + imm_u; end
            OPC_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we   = 1'b1;
                    rd_data = pc_plus4;
                    next_pc = (rs1_data + imm_i) & ~W'(1);
                end
            end
            OPC_BRANCH: if (br_taken) next_pc = pc + imm_b;
            OPC_LOAD: begin
                rd_we = 1'b1;
                unique case (funct3)
                    3'b000:  rd_data = {{(W-8){load_byte[7]}}, load_byte};
                    3'b001:  rd_data = {{(W-16){load_half[15]}}, load_half};
                    3'b010:  rd_data = mem_rdata;
                    3'b100:  rd_data = {{(W-8){1'b0}}, load_byte};
                    3'b101:  rd_data = {{(W-16){1'b0}}, load_half};
                    default: rd_we   = 1'b0;
                endcase
            end
            OPC_STORE: begin
                unique case (funct3)
                    3'b000: begin
                        mem_be     = 4'b0001 << mem_addr[1:0];
                        store_data = {4{rs2_data[7:0]}};
                    end
                    3'b001: begin
                        mem_be     = mem_addr[1] ? 4'b1100 : 4'b0011;
                        store_data = {2{rs2_data[15:0]}};
                    end
                    3'b010: begin
                        mem_be     = 4'b1111;
                        store_data = rs2_data;
                    end
                    default: mem_be = 4'b0000;
                endcase
            end
            OPC_OPIMM, OPC_OP: begin rd_we = 1'b1; rd_data = alu_y; end
            default: rd_we = 1'b0;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_rv32i_core.sv
// ============================================================================
// Module   : tb_rv32i_core
// Brief    : Directed self-checking bench for rv32i_core via backdoor access.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rv32i_core;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rv32i_core dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;

    function automatic logic [31:0] rreg(input int n);
        return dut.u_regs_0.regs[n[4:0]];
    endfunction

    // Holds reset, fills imem with ADDI x0,x0,0; program words follow via put().
    task automatic begin_prog();
        rst_n = 1'b0;
        for (int i = 0; i < 128; i++) dut.u_inst_mem_0.inst_mem[i] = 32'h0000_0013;
    endtask
    task automatic put(input int a, input logic [31:0] w);
        dut.u_inst_mem_0.inst_mem[a[11:0]] = w;
    endtask
    task automatic release_rst();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_harness(input logic [11:0] expect_imm, input logic [31:0] x27_exp);
        begin_prog();
        put(0,  enc_i(12'd1,   0, 3'b000, 3, OPI));
        put(1,  enc_i(12'hF80, 0, 3'b000, 4, OPI));
        put(2,  enc_s(12'd5,   4, 0, 3'b000));
        put(3,  enc_i(12'd5,   0, 3'b000, 5, LD));
        put(4,  enc_b(13'h20,  5, 4, 3'b001));
        put(5,  enc_i(12'd2,   0, 3'b000, 3, OPI));
        put(6,  enc_i(12'd5,   0, 3'b100, 6, LD));
        put(7,  enc_i(expect_imm, 0, 3'b000, 7, OPI));
        put(8,  enc_b(13'h10,  7, 6, 3'b001));
        put(9,  enc_i(12'd1,   0, 3'b000, 27, OPI));
        put(10, enc_i(12'd1,   0, 3'b000, 26, OPI));
        put(11, 32'h0000_006F);
        put(12, enc_i(12'd1,   0, 3'b000, 26, OPI));
        put(13, 32'h0000_006F);
        release_rst();
        for (int i = 0; i < 500 && rreg(26) != 32'd1; i++) @(posedge clk);
        #1;
        check("harness_done_x26", rreg(26), 32'd1);
        check("harness_x27",      rreg(27), x27_exp);
        check("harness_x3",       rreg(3),  32'd2);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset and fetch
        begin_prog();
        put(0, enc_i(12'd5,   0, 3'b000, 1, OPI));
        put(1, enc_i(12'hFF9, 1, 3'b000, 2, OPI));
        @(negedge clk);
        check("reset_pc", dut.pc, 32'h0);
        check("reset_x1", rreg(1), 32'h0);
        release_rst();
        step(2);
        check("fetch_x1", rreg(1), 32'd5);
        check("fetch_x2", rreg(2), 32'hFFFF_FFFE);
        check("fetch_x0", rreg(0), 32'h0);
        check("fetch_pc", dut.pc, 32'h8);
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", dut.pc, 32'h0);
        check("async_rst_x1", rreg(1), 32'h0);

        // ALU and shifts
        begin_prog();
        put(0, enc_u(20'h80000, 5));
        put(1, enc_i(12'h404, 5, 3'b101, 6, OPI));
        put(2, enc_i(12'h004, 5, 3'b101, 7, OPI));
        put(3, enc_r(7'h00, 0, 5, 3'b010, 8));
        put(4, enc_r(7'h00, 0, 5, 3'b011, 9));
        put(5, enc_r(7'h00, 5, 5, 3'b000, 10));
        put(6, enc_r(7'h20, 5, 0, 3'b000, 11));
        put(7, enc_i(12'hFFF, 0, 3'b011, 12, OPI));
        put(8, enc_i(12'hFFF, 5, 3'b100, 13, OPI));
        put(9, enc_i(12'd31,  8, 3'b001, 14, OPI));
        release_rst();
        step(10);
        check("srai", rreg(6),  32'hF800_0000);
        check("srli", rreg(7),  32'h0800_0000);
        check("slt",  rreg(8),  32'd1);
        check("sltu", rreg(9),  32'd0);
        check("add_wrap", rreg(10), 32'h0);
        check("sub",  rreg(11), 32'h8000_0000);
        check("sltiu_neg", rreg(12), 32'd1);
        check("xori", rreg(13), 32'h7FFF_FFFF);
        check("slli", rreg(14), 32'h8000_0000);

        // Loads and stores
        begin_prog();
        put(0,  enc_u(20'h80FF8, 1));
        put(1,  enc_i(12'hF01, 1, 3'b000, 1, OPI));
        put(2,  enc_s(12'd0, 1, 0, 3'b010));
        put(3,  enc_i(12'd0, 0, 3'b000, 2, LD));
        put(4,  enc_i(12'd1, 0, 3'b000, 3, LD));
        put(5,  enc_i(12'd2, 0, 3'b000, 4, LD));
        put(6,  enc_i(12'd2, 0, 3'b100, 5, LD));
        put(7,  enc_i(12'd3, 0, 3'b000, 6, LD));
        put(8,  enc_i(12'd3, 0, 3'b100, 7, LD));
        put(9,  enc_u(20'h0000C, 8));
        put(10, enc_i(12'hEEF, 8, 3'b000, 8, OPI));
        put(11, enc_s(12'd2, 8, 0, 3'b001));
        put(12, enc_i(12'd0, 0, 3'b010, 9, LD));
        put(13, enc_i(12'd2, 0, 3'b001, 10, LD));
        put(14, enc_i(12'd2, 0, 3'b101, 11, LD));
        release_rst();
        step(15);
        check("lb0",  rreg(2), 32'h0000_0001);
        check("lb1",  rreg(3), 32'h0000_007F);
        check("lb2",  rreg(4), 32'hFFFF_FFFF);
        check("lbu2", rreg(5), 32'h0000_00FF);
        check("lb3",  rreg(6), 32'hFFFF_FF80);
        check("lbu3", rreg(7), 32'h0000_0080);
        check("sh_lw", rreg(9),  32'hBEEF_7F01);
        check("lh2",   rreg(10), 32'hFFFF_BEEF);
        check("lhu2",  rreg(11), 32'h0000_BEEF);

        // Branches, jumps, x0 and NOPs
        begin_prog();
        put(0,  enc_i(12'hFFF, 0, 3'b000, 7, OPI));
        put(1,  enc_i(12'd1,   0, 3'b000, 8, OPI));
        put(2,  enc_b(13'd8, 8, 7, 3'b100));
        put(3,  enc_i(12'd1,   0, 3'b000, 10, OPI));
        put(4,  enc_j(21'd8, 1));
        put(5,  enc_i(12'd1,   0, 3'b000, 11, OPI));
        put(6,  enc_i(12'd13,  1, 3'b000, 1, 7'b1100111));
        put(7,  enc_i(12'd1,   0, 3'b000, 12, OPI));
        put(8,  enc_b(13'd8, 8, 7, 3'b110));
        put(9,  enc_i(12'd1,   0, 3'b000, 13, OPI));
        put(10, enc_i(12'd9,   0, 3'b000, 0, OPI));
        put(11, 32'h0000_0073);
        put(12, 32'hFFFF_FFFF);
        put(13, enc_i(12'd2,   0, 3'b000, 14, OPI));
        release_rst();
        step(4);
        check("jal_pc", dut.pc, 32'h18);
        check("jal_link", rreg(1), 32'h14);
        check("blt_skip", rreg(10), 32'h0);
        step(1);
        check("jalr_pc", dut.pc, 32'h20);
        check("jalr_link", rreg(1), 32'h1C);
        step(2);
        check("bltu_not_taken", rreg(13), 32'd1);
        step(1);
        check("x0_write", rreg(0), 32'h0);
        check("x0_pc", dut.pc, 32'h2C);
        step(1);
        check("ecall_pc", dut.pc, 32'h30);
        step(1);
        check("unknown_pc", dut.pc, 32'h34);
        check("nop_no_write", rreg(13), 32'd1);
        check("jal_skip", rreg(11), 32'h0);
        check("jalr_skip", rreg(12), 32'h0);
        step(1);
        check("after_nops", rreg(14), 32'd2);

        // Pass/fail convention, intact and with a corrupted expected value
        run_harness(12'h080, 32'd1);
        run_harness(12'h081, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
